// File: rtl/button_press_ctrl.sv
// Debounced push-button controller: synchronizes a raw active-low button, accepts
// presses after a stable debounce window, and holds a visual pressed state for N frames.
module button_press_ctrl #(
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int HOLD_FRAMES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       frame_tick,
    input  logic       enable,
    output logic       press_pulse,
    output logic       btn_down,
    output logic [7:0] press_count
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_ZERO = {DCNT_W{1'b0}};
    localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
    localparam logic [7:0]        HOLD_LOAD = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    logic              sync1_r;
    logic              sync2_r;
    logic              sync_lvl_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic [DCNT_W-1:0] dcnt_r;
    logic [DCNT_W-1:0] dcnt_nxt_s;
    logic [7:0]        hcnt_r;
    logic              press_set_s;
    logic              pressed_vis_s;
    logic              press_pulse_r;
    logic              btn_down_r;
    logic [7:0]        press_count_r;

    assign sync_lvl_s = ~sync2_r;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    // FSM state and debounce counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            dcnt_r  <= DCNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            dcnt_r  <= dcnt_nxt_s;
        end
    end

    // Next-state and debounce-count logic; disable overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        dcnt_nxt_s  = dcnt_r;
        if (!enable) begin
            state_nxt_s = IDLE;
            dcnt_nxt_s  = DCNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (sync_lvl_s) begin
                        state_nxt_s = DB_PRESS;
                        dcnt_nxt_s  = DCNT_ZERO;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                DB_PRESS: begin
                    if (!sync_lvl_s) begin
                        state_nxt_s = IDLE;
                        dcnt_nxt_s  = DCNT_ZERO;
                    end else if (dcnt_r == DCNT_LAST) begin
                        state_nxt_s = PRESSED;
                    end else begin
                        dcnt_nxt_s = dcnt_r + DCNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_lvl_s) begin
                        state_nxt_s = DB_RELEASE;
                        dcnt_nxt_s  = DCNT_ZERO;
                    end else begin
                        state_nxt_s = PRESSED;
                    end
                end
                DB_RELEASE: begin
                    if (sync_lvl_s) begin
                        state_nxt_s = PRESSED;
                    end else if (dcnt_r == DCNT_LAST) begin
                        state_nxt_s = IDLE;
                        dcnt_nxt_s  = DCNT_ZERO;
                    end else begin
                        dcnt_nxt_s = dcnt_r + DCNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    dcnt_nxt_s  = DCNT_ZERO;
                end
            endcase
        end
    end

    // Output decode: a press is only a DB_PRESS->PRESSED transition, never a release bounce.
    always_comb begin
        press_set_s   = 1'b0;
        pressed_vis_s = 1'b0;
        case (state_r)
            DB_PRESS: begin
                press_set_s   = (state_nxt_s == PRESSED);
                pressed_vis_s = 1'b0;
            end
            PRESSED, DB_RELEASE: begin
                press_set_s   = 1'b0;
                pressed_vis_s = 1'b1;
            end
            default: begin
                press_set_s   = 1'b0;
                pressed_vis_s = 1'b0;
            end
        endcase
    end

    // Registered press pulse and the press counter it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_pulse_r <= 1'b0;
            press_count_r <= 8'd0;
        end else begin
            press_pulse_r <= press_set_s;
            if (press_pulse_r) begin
                press_count_r <= press_count_r + 8'd1;
            end
        end
    end

    // Frame hold counter: reload on a press beats a same-cycle frame decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_r <= 8'd0;
        end else if (!enable) begin
            hcnt_r <= 8'd0;
        end else if (press_pulse_r) begin
            hcnt_r <= HOLD_LOAD;
        end else if (frame_tick && (hcnt_r != 8'd0)) begin
            hcnt_r <= hcnt_r - 8'd1;
        end
    end

    // Visual pressed state, one cycle behind state/hcnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_down_r <= 1'b0;
        end else begin
            btn_down_r <= pressed_vis_s || (hcnt_r != 8'd0);
        end
    end

    assign press_pulse = press_pulse_r;
    assign btn_down    = btn_down_r;
    assign press_count = press_count_r;

endmodule

// File: tb/tb_button_press_ctrl.sv
// Self-checking bench for button_press_ctrl: directed steps plus random bursts,
// checked every cycle against a run-length debounce reference model.
module tb_button_press_ctrl;

    localparam int D = 4;
    localparam int H = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       frame_tick;
    logic       enable;
    logic       press_pulse;
    logic       btn_down;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    // Reference model: pressed level seen by the debouncer two edges late; a level
    // change is accepted after D+1 consecutive opposite samples.
    bit         m_s1, m_s2, m_acc, m_pulse, m_down;
    int         m_run, m_hold;
    logic [7:0] m_count;

    int ft_period = 0;
    int cyc_n     = 0;
    bit ft_rand   = 1'b0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    button_press_ctrl #(.DEBOUNCE_CYCLES(D), .HOLD_FRAMES(H)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .frame_tick  (frame_tick),
        .enable      (enable),
        .press_pulse (press_pulse),
        .btn_down    (btn_down),
        .press_count (press_count)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit sync;
        bit new_pulse;
        bit new_down;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_acc = 1'b0; m_run = 0;
            m_pulse = 1'b0; m_down = 1'b0; m_hold = 0; m_count = 8'd0;
        end else begin
            sync     = m_s2;
            new_down = m_acc || (m_hold != 0);
            if (m_pulse) m_count = m_count + 8'd1;
            if (!enable) m_hold = 0;
            else if (m_pulse) m_hold = H;
            else if (frame_tick && m_hold > 0) m_hold = m_hold - 1;
            new_pulse = 1'b0;
            if (!enable) begin
                m_acc = 1'b0;
                m_run = 0;
            end else if (sync != m_acc) begin
                m_run = m_run + 1;
                if (m_run == D + 1) begin
                    m_acc     = sync;
                    m_run     = 0;
                    new_pulse = sync;
                end
            end else begin
                m_run = 0;
            end
            m_pulse = new_pulse;
            m_down  = new_down;
            m_s2    = m_s1;
            m_s1    = ~btn_n;
        end
    endtask

    // One clock: update the model at the edge, compare at the falling edge, drive frame_tick.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("press_pulse", {7'd0, press_pulse}, {7'd0, m_pulse});
        check("btn_down",    {7'd0, btn_down},    {7'd0, m_down});
        check("press_count", press_count,         m_count);
        cyc_n++;
        frame_tick = ((ft_period != 0) && (cyc_n % ft_period == 0)) ||
                     (ft_rand && ($urandom_range(0, 7) == 0));
    endtask

    task automatic wait_pulse(output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (press_pulse !== 1'b1 && cnt < 60);
    endtask

    task automatic press_release();
        btn_n = 1'b0;
        repeat (D + 8) cyc();
        btn_n = 1'b1;
        repeat (D + 8) cyc();
    endtask

    initial begin
        rst = 1'b1; btn_n = 1'b1; enable = 1'b1; frame_tick = 1'b0;
        repeat (3) cyc();
        check("rst_pulse", {7'd0, press_pulse}, 8'd0);
        check("rst_down",  {7'd0, btn_down},    8'd0);
        check("rst_count", press_count,         8'd0);

        // Clean press
        rst = 1'b0;
        cyc();
        btn_n = 1'b0;
        wait_pulse(n);
        check("clean_latency", 8'(n), 8'(D + 3));
        check("clean_down_early", {7'd0, btn_down}, 8'd0);
        cyc();
        check("clean_count", press_count, 8'd1);
        check("clean_down", {7'd0, btn_down}, 8'd1);

        // Release with periodic frame ticks; hold then expires
        ft_period = 20;
        btn_n = 1'b1;
        repeat (60) cyc();
        check("tap_down_off", {7'd0, btn_down}, 8'd0);
        ft_period = 0;

        // Bounce: 3 low, 2 high, then held low
        btn_n = 1'b0; repeat (3) cyc();
        btn_n = 1'b1; repeat (2) cyc();
        btn_n = 1'b0;
        pulses = 0;
        repeat (40) begin
            cyc();
            if (press_pulse === 1'b1) pulses++;
        end
        check("bounce_pulses", 8'(pulses), 8'd1);

        // Reset mid-DB_PRESS with button held
        btn_n = 1'b1; repeat (20) cyc();
        btn_n = 1'b0; repeat (5) cyc();
        rst = 1'b1; cyc();
        check("rst_mid_pulse", {7'd0, press_pulse}, 8'd0);
        rst = 1'b0;
        wait_pulse(n);
        check("rst_latency", 8'(n), 8'(D + 3));

        // Disable while PRESSED with hold loaded, then re-enable with button held
        cyc();
        enable = 1'b0;
        cyc();
        check("en_down_lag", {7'd0, btn_down}, 8'd1);
        cyc();
        check("en_down_off", {7'd0, btn_down}, 8'd0);
        check("en_pulse", {7'd0, press_pulse}, 8'd0);
        enable = 1'b1;
        wait_pulse(n);
        check("enable_latency", 8'(n), 8'(D + 1));

        // Random bursts with glitches, enable drops, resets and frame ticks
        ft_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            btn_n = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) begin
                enable = ($urandom_range(0, 49) != 0);
                rst    = ($urandom_range(0, 199) == 0);
                cyc();
            end
        end
        rst = 1'b0; enable = 1'b1; ft_rand = 1'b0; btn_n = 1'b1;

        // Counter wrap
        rst = 1'b1; cyc();
        rst = 1'b0;
        repeat (10) cyc();
        for (int i = 0; i < 256; i++) press_release();
        check("wrap_256", press_count, 8'd0);
        press_release();
        check("wrap_257", press_count, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
